// File: rtl/econet_handshake_ctrl.sv
// econet_handshake_ctrl: Econet four-way handshake (scout/ACK/data/ACK) with per-wait-state timeout.
// Optional broadcast acceptance in IDLE is enabled by defining ECONET_BROADCAST_EN.
module econet_handshake_ctrl #(
  parameter int TIMEOUT_CYCLES = 16384,
  parameter int TMR_W = 15
) (
  input  logic        econet_clk,
  input  logic        valid_rst,
  input  logic        rx_frame_valid,
  input  logic [15:0] rx_src,
  input  logic [15:0] rx_dst,
  input  logic [7:0]  rx_ctrl,
  input  logic [7:0]  rx_port,
  input  logic [7:0]  listen_port,
  input  logic        listen_any,
  output logic        tx_req,
  output logic [15:0] tx_dest,
  input  logic        tx_done,
  output logic        rx_inhibit,
  output logic        xfer_done,
  output logic        xfer_abort,
  output logic [15:0] xfer_src,
  output logic [7:0]  xfer_ctrl,
  output logic [7:0]  xfer_port,
  output logic        bcast_rx,
  output logic        busy,
  output logic [2:0]  state
);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SCOUT_ACK = 3'd1,
    WAIT_DATA = 3'd2,
    DATA_ACK  = 3'd3,
    WAIT_TX   = 3'd4,
    WAIT_TX2  = 3'd5
  } state_t;
  state_t cur, nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic tx_req_nxt, done_nxt, abort_nxt, bcast_nxt, latch;
  logic port_ok, is_bcast, waiting, expired;
  assign port_ok  = rx_port != 8'd0 && (listen_any || rx_port == listen_port);
  assign is_bcast = rx_dst == 16'hFFFF;
  assign waiting  = cur == WAIT_TX || cur == WAIT_DATA || cur == WAIT_TX2;
  assign expired  = timer == TMR_W'(TIMEOUT_CYCLES - 1);
  always_comb begin
    nxt        = cur;
    tx_req_nxt = 1'b0;
    done_nxt   = 1'b0;
    abort_nxt  = 1'b0;
    bcast_nxt  = 1'b0;
    latch      = 1'b0;
    unique case (cur)
      IDLE: if (rx_frame_valid && port_ok) begin
`ifdef ECONET_BROADCAST_EN
        latch     = 1'b1;
        bcast_nxt = is_bcast;
        nxt       = is_bcast ? IDLE : SCOUT_ACK;
`else
        latch = !is_bcast;
        nxt   = is_bcast ? IDLE : SCOUT_ACK;
`endif
      end
      SCOUT_ACK: begin
        tx_req_nxt = 1'b1;
        nxt        = WAIT_TX;
      end
      DATA_ACK: begin
        tx_req_nxt = 1'b1;
        nxt        = WAIT_TX2;
      end
      WAIT_TX: begin
        nxt       = tx_done ? WAIT_DATA : expired ? IDLE : WAIT_TX;
        abort_nxt = !tx_done && expired;
      end
      WAIT_DATA: begin
        nxt       = (rx_frame_valid && rx_src == xfer_src) ? DATA_ACK : expired ? IDLE : WAIT_DATA;
        abort_nxt = !(rx_frame_valid && rx_src == xfer_src) && expired;
      end
      WAIT_TX2: begin
        nxt       = (tx_done || expired) ? IDLE : WAIT_TX2;
        done_nxt  = tx_done;
        abort_nxt = !tx_done && expired;
      end
      default: nxt = IDLE;
    endcase
    // timer restarts on every state entry and only runs while waiting
    timer_nxt = (nxt != cur || !waiting) ? '0 : timer + 1'b1;
  end
  always_ff @(posedge econet_clk or posedge valid_rst) begin
    if (valid_rst) begin
      cur        <= IDLE;
      timer      <= '0;
      tx_req     <= 1'b0;
      tx_dest    <= '0;
      rx_inhibit <= 1'b0;
      xfer_done  <= 1'b0;
      xfer_abort <= 1'b0;
      xfer_src   <= '0;
      xfer_ctrl  <= '0;
      xfer_port  <= '0;
      bcast_rx   <= 1'b0;
      busy       <= 1'b0;
      state      <= 3'd0;
    end else begin
      cur        <= nxt;
      timer      <= timer_nxt;
      tx_req     <= tx_req_nxt;
      rx_inhibit <= nxt != IDLE && nxt != WAIT_DATA;
      xfer_done  <= done_nxt;
      xfer_abort <= abort_nxt;
      bcast_rx   <= bcast_nxt;
      busy       <= nxt != IDLE;
      state      <= nxt;
      if (tx_req_nxt) tx_dest <= xfer_src;
      if (latch) begin
        xfer_src  <= rx_src;
        xfer_ctrl <= rx_ctrl;
        xfer_port <= rx_port;
      end
    end
  end
endmodule

// File: tb/tb_econet_handshake_ctrl.sv
// tb_econet_handshake_ctrl: directed checks of the handshake controller with a 64-cycle timeout.
module tb_econet_handshake_ctrl;
  logic        econet_clk = 1'b0;
  logic        valid_rst = 1'b1;
  logic        rx_frame_valid = 1'b0;
  logic [15:0] rx_src = '0, rx_dst = '0;
  logic [7:0]  rx_ctrl = '0, rx_port = '0, listen_port = '0;
  logic        listen_any = 1'b0, tx_done = 1'b0;
  logic        tx_req, rx_inhibit, xfer_done, xfer_abort, bcast_rx, busy;
  logic [15:0] tx_dest, xfer_src;
  logic [7:0]  xfer_ctrl, xfer_port;
  logic [2:0]  state;
  int total = 0, bad = 0;
  int n_req = 0, n_done = 0, n_abort = 0, n_bcast = 0;

  econet_handshake_ctrl #(.TIMEOUT_CYCLES(64), .TMR_W(15)) dut (
    .econet_clk(econet_clk), .valid_rst(valid_rst), .rx_frame_valid(rx_frame_valid),
    .rx_src(rx_src), .rx_dst(rx_dst), .rx_ctrl(rx_ctrl), .rx_port(rx_port),
    .listen_port(listen_port), .listen_any(listen_any), .tx_req(tx_req), .tx_dest(tx_dest),
    .tx_done(tx_done), .rx_inhibit(rx_inhibit), .xfer_done(xfer_done), .xfer_abort(xfer_abort),
    .xfer_src(xfer_src), .xfer_ctrl(xfer_ctrl), .xfer_port(xfer_port), .bcast_rx(bcast_rx),
    .busy(busy), .state(state));

  always #5 econet_clk = ~econet_clk;

  always @(negedge econet_clk) begin
    n_req   <= n_req + int'(tx_req);
    n_done  <= n_done + int'(xfer_done);
    n_abort <= n_abort + int'(xfer_abort);
    n_bcast <= n_bcast + int'(bcast_rx);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k = 1);
    repeat (k) @(posedge econet_clk);
    #1;
  endtask

  task automatic frame(input logic [15:0] src, input logic [15:0] dst, input logic [7:0] port);
    rx_src = src; rx_dst = dst; rx_port = port; rx_ctrl = 8'h80;
    rx_frame_valid = 1'b1;
    step();
    rx_frame_valid = 1'b0;
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  task automatic clear_counts();
    @(posedge econet_clk);
    #1;
    n_req = 0; n_done = 0; n_abort = 0; n_bcast = 0;
  endtask

  initial begin
    int n;
    step(2);
    chk("rst_state", 32'(state), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_txdest", 32'(tx_dest), 0);
    chk("rst_inhibit", 32'(rx_inhibit), 0);
    valid_rst = 1'b0;
    clear_counts();
    listen_port = 8'hD1;
    frame(16'h0102, 16'h0001, 8'hD1);
    chk("scout_state", 32'(state), 1);
    chk("scout_inhibit", 32'(rx_inhibit), 1);
    chk("scout_src", 32'(xfer_src), 32'h0102);
    chk("scout_port", 32'(xfer_port), 32'hD1);
    chk("scout_noreq_yet", 32'(tx_req), 0);
    step();
    chk("ack1_req", 32'(tx_req), 1);
    chk("ack1_dest", 32'(tx_dest), 32'h0102);
    chk("ack1_state", 32'(state), 4);
    step(9);
    pulse_done();
    chk("wdata_state", 32'(state), 2);
    chk("wdata_inhibit", 32'(rx_inhibit), 0);
    frame(16'h0305, 16'h0001, 8'hD1);
    chk("other_src_ignored", 32'(state), 2);
    frame(16'h0102, 16'h0001, 8'hD1);
    chk("data_ack_state", 32'(state), 3);
    step();
    chk("ack2_req", 32'(tx_req), 1);
    chk("ack2_dest", 32'(tx_dest), 32'h0102);
    chk("wtx2_state", 32'(state), 5);
    pulse_done();
    chk("done_pulse", 32'(xfer_done), 1);
    chk("done_src_held", 32'(xfer_src), 32'h0102);
    chk("done_state", 32'(state), 0);
    step(2);
    chk("req_count", 32'(n_req), 2);
    chk("done_count", 32'(n_done), 1);
    chk("abort_count0", 32'(n_abort), 0);

    clear_counts();
    listen_port = 8'h99;
    frame(16'h0102, 16'h0001, 8'hD1);
    step(3);
    chk("nolisten_busy", 32'(busy), 0);
    chk("nolisten_req", 32'(n_req), 0);
    listen_any = 1'b1;
    frame(16'h0102, 16'h0001, 8'h00);
    chk("port0_ignored", 32'(state), 0);
    frame(16'h0102, 16'h0001, 8'hD1);
    chk("any_accepted", 32'(state), 1);
    step();
    pulse_done();
    chk("to_wait_data", 32'(state), 2);
    n = 0;
    while (!xfer_abort && n < 200) begin
      step();
      n++;
    end
    chk("abort_latency", 32'(n), 64);
    chk("abort_state", 32'(state), 0);

    clear_counts();
    frame(16'h0102, 16'h0001, 8'hD1);
    step();
    pulse_done();
    step(63);
    chk("pre_expiry_state", 32'(state), 2);
    frame(16'h0102, 16'h0001, 8'hD1);
    chk("expiry_match_state", 32'(state), 3);
    chk("expiry_no_abort", 32'(xfer_abort), 0);
    step();
    chk("rst_pre_state", 32'(state), 5);
    #2 valid_rst = 1'b1;
    #1;
    chk("arst_state", 32'(state), 0);
    chk("arst_txdest", 32'(tx_dest), 0);
    chk("arst_src", 32'(xfer_src), 0);
    chk("arst_inhibit", 32'(rx_inhibit), 0);
    chk("arst_busy", 32'(busy), 0);
    step();
    valid_rst = 1'b0;
    step(3);
    chk("arst_no_done", 32'(n_done), 0);
    chk("arst_no_abort", 32'(n_abort), 0);
    frame(16'h0102, 16'h0001, 8'hD1);
    chk("post_rst_accept", 32'(state), 1);
    valid_rst = 1'b1;
    step();
    valid_rst = 1'b0;

    clear_counts();
    frame(16'h0A0B, 16'hFFFF, 8'hD1);
    step(3);
    chk("bc_no_req", 32'(n_req), 0);
    chk("bc_state", 32'(state), 0);
`ifdef ECONET_BROADCAST_EN
    chk("bc_pulses", 32'(n_bcast), 1);
    chk("bc_src", 32'(xfer_src), 32'h0A0B);
`else
    chk("bc_pulses", 32'(n_bcast), 0);
    chk("bc_src", 32'(xfer_src), 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/econet_handshake_ctrl.md
ECONET_HANDSHAKE_CTRL -- requirements
Module: econet_handshake_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16384, econet_clk cycles allowed per wait state before abort.
REQ-002 SHALL have parameter TMR_W, default 15, timeout counter width; TIMEOUT_CYCLES < 2^TMR_W.
REQ-003 Ports, in order:
- econet_clk  in  1  clock.
- valid_rst  in  1  reset; asynchronous, active-high.
- rx_frame_valid  in  1  one-cycle pulse: good-FCS frame for our station.
- rx_src  in  16  frame source {net,stn}, valid with pulse.
- rx_dst  in  16  frame destination {net,stn}, valid with pulse.
- rx_ctrl  in  8  scout control byte.
- rx_port  in  8  scout port.
- listen_port  in  8  accepted port.
- listen_any  in  1  accept any non-zero port.
- tx_req  out  1  one-cycle pulse: send ACK frame.
- tx_dest  out  16  ACK destination, stable from tx_req until tx_done.
- tx_done  in  1  one-cycle pulse: ACK transmitted.
- rx_inhibit  out  1  drives receiver inhibit.
- xfer_done  out  1  one-cycle pulse: four-way handshake complete.
- xfer_abort  out  1  one-cycle pulse: handshake abandoned.
- xfer_src  out  16  latched scout source.
- xfer_ctrl  out  8  latched scout control.
- xfer_port  out  8  latched scout port.
- bcast_rx  out  1  one-cycle pulse: broadcast accepted (see REQ-022).
- busy  out  1  high in any state except IDLE.
- state  out  3  current state encoding.

Function
REQ-004 States: IDLE=0, SCOUT_ACK=1, WAIT_DATA=2, DATA_ACK=3, WAIT_TX=4 (waiting tx_done for SCOUT_ACK), WAIT_TX2=5 (waiting tx_done for DATA_ACK).
REQ-005 IDLE: rx_frame_valid with rx_port!=0 and (listen_any or rx_port==listen_port) SHALL latch xfer_src/ctrl/port and go SCOUT_ACK next cycle; else stay IDLE.
REQ-006 SCOUT_ACK: SHALL pulse tx_req for exactly one cycle with tx_dest=xfer_src, then go WAIT_TX.
REQ-007 WAIT_TX: tx_done SHALL move to WAIT_DATA and clear the timer.
REQ-008 WAIT_DATA: rx_frame_valid with rx_src==xfer_src SHALL go DATA_ACK; frames from other sources SHALL be ignored.
REQ-009 DATA_ACK: SHALL pulse tx_req one cycle, tx_dest=xfer_src, then go WAIT_TX2.
REQ-010 WAIT_TX2: tx_done SHALL pulse xfer_done next cycle and return to IDLE.
REQ-011 Timer SHALL clear on every state entry and increment each cycle in WAIT_TX, WAIT_DATA, WAIT_TX2; reaching TIMEOUT_CYCLES-1 SHALL pulse xfer_abort and go IDLE.
REQ-012 Same-cycle qualifying event (tx_done or matching frame) and timeout expiry: event SHALL win, no abort.
REQ-013 rx_frame_valid in SCOUT_ACK, DATA_ACK, WAIT_TX, WAIT_TX2 SHALL be ignored.
REQ-014 tx_done outside WAIT_TX/WAIT_TX2 SHALL be ignored.
REQ-015 rx_inhibit SHALL be high in SCOUT_ACK, WAIT_TX, DATA_ACK, WAIT_TX2; low otherwise.
REQ-016 xfer_src/ctrl/port SHALL hold until next accepted scout; they SHALL remain valid during the xfer_done cycle.
REQ-017 All outputs SHALL be registered; latency rx_frame_valid(scout) -> tx_req SHALL be 2 cycles.

Reset
REQ-018 valid_rst high SHALL force IDLE, timer=0, and all outputs 0 (tx_dest, xfer_* = 0) asynchronously.
REQ-019 Reset mid-handshake SHALL abandon it without xfer_abort or xfer_done pulse.
REQ-020 First qualifying scout after valid_rst deasserts SHALL be accepted normally.

Configuration
REQ-021 Macro ECONET_BROADCAST_EN SHALL control broadcast handling.
REQ-022 Defined: in IDLE, a qualifying scout with rx_dst==16'hFFFF SHALL latch xfer_* and pulse bcast_rx next cycle, remain IDLE, emit no tx_req.
REQ-023 Undefined: rx_dst==16'hFFFF frames SHALL be ignored; bcast_rx SHALL be tied 0.

Verification
REQ-024 Scout src=16'h0102 port=8'hD1, listen_port=D1; tx_done after 10 cycles; data from 0102; tx_done -> tx_req twice, tx_dest=0102, one xfer_done, state returns 0.
REQ-025 Scout port=D1, listen_port=99, listen_any=0 -> no tx_req, busy stays 0; repeat with listen_any=1 -> accepted.
REQ-026 TIMEOUT_CYCLES=64; scout accepted, tx_done, no data -> xfer_abort exactly 64 cycles after WAIT_DATA entry, state 0.
REQ-027 WAIT_DATA: frame from 0305 then 0102 -> 0305 ignored, DATA_ACK entered only on 0102; matching frame on expiry cycle -> no abort.
REQ-028 valid_rst pulse during WAIT_TX2 -> all outputs 0 immediately, no xfer_done/xfer_abort.
REQ-029 With ECONET_BROADCAST_EN, scout rx_dst=FFFF port=D1 -> bcast_rx one pulse, no tx_req; without macro -> nothing.
